// File: rtl/pm_pkg.sv
// Shared constants and types for the pattern-matching peripheral.
// Optional match interrupt is enabled with PM_MATCH_IRQ_EN.
package pm_pkg;

    localparam logic [31:0] PM_BASE_ADDR = 32'h0040_0000;

    // Word offsets within the decode window (daddr[4:2])
    localparam logic [2:0] OFF_CTRL        = 3'd0;
    localparam logic [2:0] OFF_PATTERN     = 3'd1;
    localparam logic [2:0] OFF_MASK        = 3'd2;
    localparam logic [2:0] OFF_DATA_STATUS = 3'd3;
    localparam logic [2:0] OFF_MATCH       = 3'd4;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_CLR = 1;
    localparam int CTRL_IE  = 2;

    localparam int ST_BUSY  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_FULL  = 2;
    localparam int ST_FOUND = 3;
    localparam int ST_OVF   = 4;
    localparam int ST_LVL   = 5;

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

endpackage

// File: rtl/pm_fifo.sv
// Synchronous FIFO with occupancy level and a synchronous flush.
// Push on full and pop on empty are ignored.
module pm_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata   = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/pm_periph.sv
// Pattern-matching bus peripheral: word FIFO, byte-serial window compare.
// Define PM_MATCH_IRQ_EN to add CTRL.IE and the registered irq output.
module pm_periph
    import pm_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = PM_BASE_ADDR,
    parameter int          FIFO_DEPTH = 4,
    parameter int          CNT_W      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwe,
    output logic [31:0] drdata
`ifdef PM_MATCH_IRQ_EN
    ,
    output logic        irq
`endif
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = (CNT_W < 16) ? CNT_W : 16;

    logic [2:0]  widx;
    logic        sel;
    logic        wr;
    logic        wr_ctrl;
    logic        push_req;
    logic        clr;

    logic        en;
    logic        ie;
    logic [31:0] pattern;
    logic [31:0] mask;
    logic        ovf;

    logic [31:0] fifo_rdata;
    logic        fifo_full;
    logic        fifo_empty;
    logic [LW-1:0] fifo_level;
    logic        pop;

    state_t      state, state_d;
    logic [31:0] shifter, shift_d;
    logic [1:0]  bcnt, bcnt_d;
    logic [31:0] window, win_d;
    logic [2:0]  fill, fill_d;
    logic [CNT_W-1:0] pos, pos_d;
    logic [CNT_W-1:0] count, cnt_d;
    logic [CNT_W-1:0] first_pos, fp_d;
    logic        found, found_d;
    logic [7:0]  nbyte;
    logic        match;

    assign widx     = daddr[4:2];
    assign sel      = (daddr[31:5] == BASE_ADDR[31:5]) && (widx <= OFF_MATCH);
    assign wr       = sel && (dwe == 4'hF) && (daddr[1:0] == 2'b00);
    assign wr_ctrl  = wr && (widx == OFF_CTRL);
    assign push_req = wr && (widx == OFF_DATA_STATUS);
    assign clr      = wr_ctrl && dwdata[CTRL_CLR];

    pm_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH),
        .LW    (LW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (clr),
        .push  (push_req),
        .wdata (dwdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en      <= 1'b0;
            pattern <= '0;
            mask    <= '0;
            ovf     <= 1'b0;
        end else begin
            if (wr_ctrl)
                en <= dwdata[CTRL_EN];
            if (wr && widx == OFF_PATTERN)
                pattern <= dwdata;
            if (wr && widx == OFF_MASK)
                mask <= dwdata;
            if (clr)
                ovf <= 1'b0;
            else if (push_req && fifo_full)
                ovf <= 1'b1;
        end
    end

`ifdef PM_MATCH_IRQ_EN
    logic ie_next;
    assign ie_next = wr_ctrl ? dwdata[CTRL_IE] : ie;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ie  <= 1'b0;
            irq <= 1'b0;
        end else begin
            ie  <= ie_next;
            irq <= !clr && found && ie_next;
        end
    end
`else
    assign ie = 1'b0;
`endif

    always_comb begin
        state_d = state;
        pop     = 1'b0;
        shift_d = shifter;
        bcnt_d  = bcnt;
        win_d   = window;
        fill_d  = fill;
        pos_d   = pos;
        cnt_d   = count;
        fp_d    = first_pos;
        found_d = found;
        match   = 1'b0;
        nbyte   = shifter[{bcnt, 3'b000} +: 8];
        unique case (state)
            IDLE: begin
                if (en && !fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    bcnt_d  = 2'd0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                win_d  = {window[23:0], nbyte};
                fill_d = (fill == 3'd4) ? 3'd4 : fill + 3'd1;
                pos_d  = pos + CNT_W'(1);
                match  = (((win_d ^ pattern) & mask) == 32'd0) &&
                         (fill_d == 3'd4);
                if (match) begin
                    if (count != {CNT_W{1'b1}})
                        cnt_d = count + CNT_W'(1);
                    if (!found) begin
                        fp_d    = pos;
                        found_d = 1'b1;
                    end
                end
                bcnt_d = bcnt + 2'd1;
                if (bcnt == 2'd3)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // CLR overrides any pop or shift happening this cycle
        if (clr) begin
            state_d = IDLE;
            pop     = 1'b0;
            win_d   = '0;
            fill_d  = '0;
            pos_d   = '0;
            cnt_d   = '0;
            fp_d    = '0;
            found_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shifter   <= '0;
            bcnt      <= '0;
            window    <= '0;
            fill      <= '0;
            pos       <= '0;
            count     <= '0;
            first_pos <= '0;
            found     <= 1'b0;
        end else begin
            state     <= state_d;
            shifter   <= shift_d;
            bcnt      <= bcnt_d;
            window    <= win_d;
            fill      <= fill_d;
            pos       <= pos_d;
            count     <= cnt_d;
            first_pos <= fp_d;
            found     <= found_d;
        end
    end

    logic [31:0] lvl32;
    logic [2:0]  lvl;
    logic [31:0] status;
    logic [31:0] match_reg;

    assign lvl32 = 32'(fifo_level);
    assign lvl   = (lvl32 > 32'd7) ? 3'd7 : lvl32[2:0];

    always_comb begin
        status           = '0;
        status[ST_BUSY]  = (state == SCAN) || !fifo_empty;
        status[ST_EMPTY] = fifo_empty;
        status[ST_FULL]  = fifo_full;
        status[ST_FOUND] = found;
        status[ST_OVF]   = ovf;
        status[ST_LVL +: 3] = lvl;
        match_reg             = '0;
        match_reg[CW-1:0]     = count[CW-1:0];
        match_reg[16 +: CW]   = first_pos[CW-1:0];
    end

    always_comb begin
        drdata = '0;
        if (sel) begin
            case (widx)
                OFF_CTRL:        drdata = {29'd0, ie, 1'b0, en};
                OFF_PATTERN:     drdata = pattern;
                OFF_MASK:        drdata = mask;
                OFF_DATA_STATUS: drdata = status;
                OFF_MATCH:       drdata = match_reg;
                default:         drdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_pm_periph.sv
// Self-checking bench for pm_periph against a byte-stream match model.
// Build with PM_MATCH_IRQ_EN to also exercise the interrupt.
module tb_pm_periph;

    localparam logic [31:0] A_CTRL   = 32'h0040_0000;
    localparam logic [31:0] A_PAT    = 32'h0040_0004;
    localparam logic [31:0] A_MASK   = 32'h0040_0008;
    localparam logic [31:0] A_DATA   = 32'h0040_000C;
    localparam logic [31:0] A_MATCH  = 32'h0040_0010;
    localparam logic [31:0] A_NONE   = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwe;
    logic [31:0] drdata;
`ifdef PM_MATCH_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0]  stream[$];
    logic [31:0] pat_m;
    logic [31:0] mask_m;

    pm_periph dut (
        .clk    (clk),
        .reset  (reset),
        .daddr  (daddr),
        .dwdata (dwdata),
        .dwe    (dwe),
        .drdata (drdata)
`ifdef PM_MATCH_IRQ_EN
        ,
        .irq    (irq)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic wr_be(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be);
        @(negedge clk);
        daddr  = a;
        dwdata = d;
        dwe    = be;
        @(negedge clk);
        dwe    = 4'h0;
        daddr  = A_NONE;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wr_be(a, d, 4'hF);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        daddr = a;
        #1;
        d = drdata;
    endtask

    // Fresh run: CLR with chosen EN/IE bits, new pattern and mask
    task automatic start(input logic [31:0] ctrl, input logic [31:0] p,
                         input logic [31:0] m);
        wr(A_CTRL, ctrl | 32'h2);
        wr(A_PAT, p);
        wr(A_MASK, m);
        pat_m  = p;
        mask_m = m;
        stream.delete();
    endtask

    task automatic push(input logic [31:0] w);
        wr(A_DATA, w);
    endtask

    task automatic log_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++)
            stream.push_back(w[8*b +: 8]);
    endtask

    // Every 4 consecutive bytes of the stream form a window, oldest byte in MSBs
    task automatic model(output int cnt, output int fp);
        logic [31:0] w;
        cnt = 0;
        fp  = 0;
        for (int i = 3; i < stream.size(); i++) begin
            w = {stream[i-3], stream[i-2], stream[i-1], stream[i]};
            if (((w ^ pat_m) & mask_m) == 32'd0) begin
                if (cnt == 0)
                    fp = i;
                cnt++;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        logic [31:0] s;
        s = 32'h1;
        for (int k = 0; k < 200 && s[0]; k++)
            rd(A_DATA, s);
        checks++;
        if (s[0] !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_timeout status=%h", name, s);
        end
    endtask

    task automatic check_match(input string name);
        int cnt, fp;
        logic [31:0] got, exp, st;
        model(cnt, fp);
        exp = {16'(fp), 16'(cnt)};
        rd(A_MATCH, got);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s match got=%h exp=%h", name, got, exp);
        end
        rd(A_DATA, st);
        checks++;
        if (st[3] !== (cnt != 0)) begin
            errors++;
            $display("FAIL %s found got=%b exp=%b", name, st[3], cnt != 0);
        end
    endtask

    function automatic logic [31:0] ab_word();
        logic [31:0] w;
        for (int b = 0; b < 4; b++)
            w[8*b +: 8] = 8'h61 + 8'($urandom_range(0, 1));
        return w;
    endfunction

    task automatic test_reset();
        logic [31:0] v;
        logic [31:0] addrs [5];
        logic [31:0] exps  [5];
        addrs = '{A_CTRL, A_PAT, A_MASK, A_DATA, A_MATCH};
        exps  = '{32'h0, 32'h0, 32'h0, 32'h2, 32'h0};
        for (int i = 0; i < 5; i++) begin
            rd(addrs[i], v);
            checks++;
            if (v !== exps[i]) begin
                errors++;
                $display("FAIL reset_reg%0d got=%h exp=%h", i, v, exps[i]);
            end
        end
    endtask

    task automatic test_single();
        logic [31:0] s;
        start(32'h1, 32'h6162_6364, 32'hFFFF_FFFF);
        push(32'h6463_6261);
        log_word(32'h6463_6261);
        repeat (3) @(negedge clk);
        rd(A_DATA, s);
        checks++;
        if (s[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_busy_e4 got=%b exp=1", s[0]);
        end
        rd(A_DATA, s);
        checks++;
        if (s !== 32'h0000_000A) begin
            errors++;
            $display("FAIL single_status_e5 got=%h exp=0000000a", s);
        end
        check_match("single");
    endtask

    task automatic test_overlap();
        start(32'h1, 32'h6161_6161, 32'hFFFF_FFFF);
        for (int i = 0; i < 2; i++) begin
            push(32'h6161_6161);
            log_word(32'h6161_6161);
        end
        wait_idle("overlap");
        check_match("overlap");
    endtask

    task automatic test_mask();
        start(32'h1, 32'h6162_0000, 32'hFFFF_0000);
        push(32'h0000_6261);
        log_word(32'h0000_6261);
        wait_idle("mask_partial");
        check_match("mask_partial");
        start(32'h1, 32'h6162_6364, 32'hFFFF_FFFF);
        push(32'h0000_6261);
        log_word(32'h0000_6261);
        wait_idle("mask_full");
        check_match("mask_full");
    endtask

    task automatic test_overflow();
        logic [31:0] s;
        logic [31:0] w;
        start(32'h0, 32'h6162_6162, 32'hFFFF_FFFF);
        for (int i = 0; i < 5; i++) begin
            w = ab_word();
            push(w);
            if (i < 4)
                log_word(w);
        end
        rd(A_DATA, s);
        checks++;
        if (s !== 32'h0000_0095) begin
            errors++;
            $display("FAIL ovf_status got=%h exp=00000095", s);
        end
        wr(A_CTRL, 32'h1);
        wait_idle("ovf_drain");
        rd(A_DATA, s);
        checks++;
        if (s[2:1] !== 2'b01 || s[7:5] !== 3'd0 || s[4] !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drained got=%h exp=empty,ovf", s);
        end
        check_match("ovf_four_words");
        wr(A_CTRL, 32'h2);
        rd(A_DATA, s);
        checks++;
        if (s !== 32'h0000_0002) begin
            errors++;
            $display("FAIL ovf_clr got=%h exp=00000002", s);
        end
    endtask

    task automatic test_decode();
        logic [31:0] v;
        start(32'h0, 32'h1234_5678, 32'h0F0F_0F0F);
        wr(32'h0040_0014, 32'hDEAD_BEEF);
        wr(32'h0000_0004, 32'hDEAD_BEEF);
        wr_be(A_PAT, 32'hDEAD_BEEF, 4'h3);
        wr(32'h0040_0006, 32'hDEAD_BEEF);
        wr(32'h0040_0016, 32'hDEAD_BEEF);
        rd(A_PAT, v);
        checks++;
        if (v !== 32'h1234_5678) begin
            errors++;
            $display("FAIL decode_pattern got=%h exp=12345678", v);
        end
        rd(A_MASK, v);
        checks++;
        if (v !== 32'h0F0F_0F0F) begin
            errors++;
            $display("FAIL decode_mask got=%h exp=0f0f0f0f", v);
        end
        rd(32'h0080_0000, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL decode_outside got=%h exp=0", v);
        end
        rd(32'h0040_0014, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL decode_hole got=%h exp=0", v);
        end
    endtask

    task automatic test_clr_mid();
        logic [31:0] v;
        start(32'h1, 32'h6162_6364, 32'hFFFF_FFFF);
        push(32'h6463_6261);
        push(32'h6463_6261);
        repeat (2) @(negedge clk);
        wr(A_CTRL, 32'h3);
        repeat (6) @(negedge clk);
        rd(A_MATCH, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL clr_mid_match got=%h exp=0", v);
        end
        rd(A_DATA, v);
        checks++;
        if (v !== 32'h2) begin
            errors++;
            $display("FAIL clr_mid_status got=%h exp=00000002", v);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        start(32'h1, 32'h6162_6364, 32'hFFFF_FFFF);
        push(32'h6463_6261);
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        daddr = A_CTRL;
        #1;
        checks++;
        if (drdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_ctrl got=%h exp=0", drdata);
        end
        @(negedge clk);
        reset = 1'b0;
        rd(A_DATA, v);
        checks++;
        if (v !== 32'h2) begin
            errors++;
            $display("FAIL rst_mid_status got=%h exp=00000002", v);
        end
        rd(A_PAT, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_pattern got=%h exp=0", v);
        end
    endtask

    task automatic test_random();
        logic [31:0] p, m, w;
        int n;
        for (int it = 0; it < 8; it++) begin
            p = ab_word();
            m = 32'hFFFF_FFFF;
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 2) == 0)
                    m[8*b +: 8] = 8'h00;
            start(32'h1, p, m);
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                w = ab_word();
                push(w);
                log_word(w);
            end
            wait_idle("random");
            check_match("random");
        end
    endtask

`ifdef PM_MATCH_IRQ_EN
    task automatic test_irq();
        logic [31:0] s;
        int f_at, i_at;
        f_at = -1;
        i_at = -1;
        start(32'h5, 32'h6162_6364, 32'hFFFF_FFFF);
        push(32'h6463_6261);
        for (int c = 0; c < 20; c++) begin
            rd(A_DATA, s);
            if (s[3] && f_at < 0)
                f_at = c;
            if (irq && i_at < 0)
                i_at = c;
        end
        checks++;
        if (f_at < 0 || i_at !== f_at + 1) begin
            errors++;
            $display("FAIL irq_timing found_at=%0d irq_at=%0d", f_at, i_at);
        end
        wr(A_CTRL, 32'h7);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clr got=%b exp=0", irq);
        end
    endtask
`endif

    initial begin
        reset  = 1'b1;
        daddr  = A_NONE;
        dwdata = 32'h0;
        dwe    = 4'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_single();
        test_overlap();
        test_mask();
        test_overflow();
        test_decode();
        test_clr_mid();
        test_reset_mid();
        test_random();
`ifdef PM_MATCH_IRQ_EN
        test_irq();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pm_periph.md
Name: pm_periph

Overview:
- Bus responder for the pattern-matching peripheral at 0x0040_0000–0x0040_0013 (five 32-bit registers).
- CPU writes 32-bit words into a small FIFO. A byte-serial engine shifts them into a 4-byte window and compares the window against a masked pattern. It counts matches and records the byte position of the first match.
- Read data goes back to the bus unit on the peripheral read-data branch. Write enables arrive ungated, so this block performs its own address decode.

Parameters:
- BASE_ADDR, 32'h0040_0000, base of the 32-byte decode window (aligned to 32 bytes).
- FIFO_DEPTH, 4, number of data words buffered (power of two, ≥2).
- CNT_W, 16, width of the match counter and the byte-position counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- daddr  in  32  CPU byte address.
- dwdata  in  32  CPU write data.
- dwe  in  4  byte write enables; only dwe==4'hF is acted on.
- drdata  out  32  read data; combinational from daddr.
- irq  out  1  present only with PM_MATCH_IRQ_EN.

Behaviour:
- Address decode: sel = (daddr[31:5]==BASE_ADDR[31:5]) && (daddr[4:2] ≤ 4). Writes take effect at the clock edge when sel && dwe==4'hF. Partial writes and writes with daddr[1:0]≠0 are ignored.
- Reads: drdata = register value when sel, else 0. Reads never have side effects. Offsets 0x14–0x1F read 0.
- Register map:
  - 0x00 CTRL (R/W): bit0 EN; bit1 CLR (write-1 pulse, always reads 0); bit2 IE (only with the macro; otherwise reads 0).
  - 0x04 PATTERN (R/W, 32 bits).
  - 0x08 MASK (R/W, 32 bits). A bit set to 1 means that bit is compared.
  - 0x0C: write = DATA push into FIFO. Read = STATUS: [0] busy, [1] fifo_empty, [2] fifo_full, [3] found, [4] ovf, [7:5] fifo level (saturating), rest 0.
  - 0x10 MATCH (RO): [CNT_W-1:0] match_count; [31:16] first_pos, the low 16 bits of the position counter.
- Reset values: CTRL=0, PATTERN=0, MASK=0, FIFO empty, window=0, fill=0, count=0, pos=0, first_pos=0, found=0, ovf=0, state IDLE, irq=0. drdata follows daddr.
- FIFO push:
  - Push when not full.
  - Push when full is dropped and sets ovf (sticky until CLR or reset).
- Engine FSM, states IDLE and SCAN:
  - IDLE: if EN && !empty, pop one word into the byte shifter, set bcnt=0, go to SCAN.
  - SCAN: each cycle, window <= {window[23:0], shifter byte bcnt} (bytes taken LSB first); fill saturates at 4; pos increments.
  - Match is evaluated on the next window value: ((win_next ^ PATTERN) & MASK)==0 && fill_next==4.
  - On a match: count increments, saturating at all-ones. If !found, first_pos <= pos (the index of the byte completing the match) and found <= 1.
  - After bcnt==3, go to IDLE.
  - Latency: a push sampled at edge E0 pops at E1; bytes are shifted and matches counted at E2..E5. A STATUS read after E5 shows busy=0 if no further words are queued.
- busy = (state==SCAN) || !empty.
- Window and pos persist across words, so matches may span word boundaries and overlapping matches all count.
- EN cleared mid-SCAN: the current word completes, then the engine stays in IDLE. Queued words are retained.
- CLR (any state): at the edge, FIFO is flushed and window, fill, pos, count, first_pos, found, ovf are zeroed; state goes to IDLE. EN, PATTERN and MASK are unchanged, except that EN takes the written bit0.
- PATTERN/MASK write during SCAN: the new value is used from the following edge's compare onward.
- pos wraps modulo 2^CNT_W. first_pos is not reloaded after wrap while found=1.
- Asynchronous reset mid-SCAN forces the reset values immediately.

Optional Feature:
- PM_MATCH_IRQ_EN defined:
  - Port irq and CTRL bit2 IE exist.
  - irq is registered and equals found && IE, so it rises one cycle after found sets.
  - irq is cleared by CLR, by IE=0, or by reset.
- Undefined: no irq port; CTRL bit2 is read-only 0; IE writes are ignored.

Decomposition:
- Package pm_pkg:
  - BASE_ADDR default.
  - Register offset constants: OFF_CTRL, OFF_PATTERN, OFF_MASK, OFF_DATA_STATUS, OFF_MATCH.
  - CTRL/STATUS bit index constants.
  - Engine state typedef {IDLE, SCAN}.
- Sub-module pm_fifo: synchronous FIFO with push, pop, full, empty, level; parameters WIDTH and DEPTH; asynchronous active-high reset; synchronous flush input driven by CLR.

Test Plan:
- Single match: MASK=FFFFFFFF, PATTERN=61626364, EN=1, push 64636261 → after 5 cycles count=1, first_pos=3, found=1, busy=0.
- Overlap/spanning: PATTERN=61616161, push 61616161 twice → count=5 (pos 3..7), first_pos=3.
- Mask: MASK=FFFF0000, PATTERN=61620000, push 00006261 → count=1, first_pos=3. Then MASK=FFFFFFFF with a fresh CLR, same push → count=0.
- Overflow: EN=0, push 5 words → level=4, full=1, ovf=1. Set EN=1 → exactly 4 words processed, then empty=1. CLR → ovf=0.
- Decode: write to 0x0040_0014, to 0x0000_0004, and to 0x0040_0004 with dwe=4'h3 → no register changes. Read of 0x0080_0000 → drdata=0.
- Reset/CLR mid-SCAN: assert reset (or write CLR) at E3 of a match-bearing word → count=0, FIFO empty, state IDLE. With the macro: irq asserts one cycle after found when IE=1, and drops on CLR.
